// File: rtl/i2c_controller_if.sv
// rtl/i2c_controller_if.sv - byte-level I2C initiator: START/repeated START, WRITE, READ, STOP
// Optional SCL clock stretching by the target is enabled with `define I2C_CLK_STRETCH_EN.
module i2c_controller_if #(
    parameter int SCL_QTR = 31
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       CMD_START,
    input  logic       CMD_STOP,
    input  logic       CMD_WR,
    input  logic       CMD_RD,
    input  logic [7:0] CMD_WDATA,
    input  logic       CMD_RD_NACK,
    output logic       BUSY,
    output logic       DONE,
    output logic       ACK_ERR,
    output logic [7:0] RDATA,
    output logic       SCL_OUT,
    input  logic       SDA_IN,
`ifdef I2C_CLK_STRETCH_EN
    input  logic       SCL_IN,
`endif
    output logic       SDA_OUT
);
    localparam int CW = 10;

    typedef enum logic [2:0] {S_IDLE, S_START, S_HOLD, S_WRITE, S_READ, S_STOP} state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_q;
    logic [3:0]  r_bit;
    logic [7:0]  r_data;
    logic        r_nack;
    logic        r_ack_smp;
    logic        r_owned;
    logic        r_busy;
    logic        r_done;
    logic        r_ack_err;
    logic [7:0]  r_rdata;
    logic        r_scl;
    logic        r_sda;

    logic        w_hold;
    logic        w_tick;
    logic        w_acc_start;
    logic        w_acc_stop;
    logic        w_acc_wr;
    logic        w_acc_rd;
    logic        w_acc_any;
    logic [3:0]  w_nxt_bit;
    logic        w_nxt_sda;

`ifdef I2C_CLK_STRETCH_EN
    // A target holding SCL low while we release it freezes the quarter timer.
    assign w_hold = r_scl & ~SCL_IN;
`else
    assign w_hold = 1'b0;
`endif

    assign w_tick      = (r_cnt == CW'(SCL_QTR - 1)) & ~w_hold;
    assign w_acc_start = ~r_busy & CMD_START;
    assign w_acc_stop  = ~r_busy & ~CMD_START & CMD_STOP & r_owned;
    assign w_acc_wr    = ~r_busy & ~CMD_START & ~CMD_STOP & CMD_WR & r_owned;
    assign w_acc_rd    = ~r_busy & ~CMD_START & ~CMD_STOP & ~CMD_WR & CMD_RD & r_owned;
    assign w_acc_any   = w_acc_start | w_acc_stop | w_acc_wr | w_acc_rd;
    assign w_nxt_bit   = r_bit + 4'd1;

    always_comb begin
        w_nxt_sda = 1'b1;
        if (r_state == S_WRITE)
            w_nxt_sda = (w_nxt_bit == 4'd8) ? 1'b1 : r_data[~w_nxt_bit[2:0]];
        else if (r_state == S_READ)
            w_nxt_sda = (w_nxt_bit == 4'd8) ? r_nack : 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_q       <= '0;
            r_bit     <= '0;
            r_data    <= '0;
            r_nack    <= 1'b0;
            r_ack_smp <= 1'b0;
            r_owned   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_rdata   <= '0;
            r_scl     <= 1'b1;
            r_sda     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_acc_any || w_hold || w_tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);

            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_acc_start) begin
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                        // Repeated START first releases SDA and raises SCL (phases 0,1).
                        r_q     <= r_owned ? 3'd0 : 3'd2;
                        r_sda   <= r_owned;
                    end else if (w_acc_stop) begin
                        r_busy  <= 1'b1;
                        r_state <= S_STOP;
                        r_q     <= 3'd0;
                        r_sda   <= 1'b0;
                    end else if (w_acc_wr) begin
                        r_busy  <= 1'b1;
                        r_state <= S_WRITE;
                        r_q     <= 3'd0;
                        r_bit   <= 4'd0;
                        r_data  <= CMD_WDATA;
                        r_sda   <= CMD_WDATA[7];
                    end else if (w_acc_rd) begin
                        r_busy  <= 1'b1;
                        r_state <= S_READ;
                        r_q     <= 3'd0;
                        r_bit   <= 4'd0;
                        r_nack  <= CMD_RD_NACK;
                        r_sda   <= 1'b1;
                    end
                end
                S_START: if (w_tick) begin
                    r_q <= r_q + 3'd1;
                    case (r_q)
                        3'd0:    r_scl <= 1'b1;
                        3'd1:    r_sda <= 1'b0;
                        3'd3:    r_scl <= 1'b0;
                        3'd5: begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_owned <= 1'b1;
                            r_state <= S_HOLD;
                        end
                        default: ;
                    endcase
                end
                S_WRITE, S_READ: if (w_tick) begin
                    case (r_q[1:0])
                        2'd0: begin
                            r_scl <= 1'b1;
                            r_q   <= 3'd1;
                        end
                        2'd1: r_q <= 3'd2;
                        2'd2: begin
                            r_scl <= 1'b0;
                            r_q   <= 3'd3;
                            if (r_bit == 4'd8)
                                r_ack_smp <= SDA_IN;
                            else if (r_state == S_READ)
                                r_data <= {r_data[6:0], SDA_IN};
                        end
                        default: begin
                            if (r_bit == 4'd8) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_HOLD;
                                if (r_state == S_WRITE)
                                    r_ack_err <= r_ack_smp;
                                else
                                    r_rdata <= r_data;
                            end else begin
                                r_bit <= w_nxt_bit;
                                r_q   <= 3'd0;
                                r_sda <= w_nxt_sda;
                            end
                        end
                    endcase
                end
                S_STOP: if (w_tick) begin
                    r_q <= r_q + 3'd1;
                    case (r_q)
                        3'd0:    r_scl <= 1'b1;
                        3'd2:    r_sda <= 1'b1;
                        3'd3: begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_owned <= 1'b0;
                            r_state <= S_IDLE;
                        end
                        default: ;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign ACK_ERR = r_ack_err;
    assign RDATA   = r_rdata;
    assign SCL_OUT = r_scl;
    assign SDA_OUT = r_sda;
endmodule
